// File: rtl/zircon_adc_pkg.sv
// Shared constants for the TLC549 sample FIFO:
// register addresses and register bit-field positions.
package zircon_adc_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_AVG    = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_DECIM_LSB  = 8;
  localparam int CTRL_THRESH_LSB = 16;
  localparam int CTRL_FIELD_W    = 8;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;

  localparam int DATA_VALID_BIT = 31;
  localparam int AVG_VALID_BIT  = 31;

endpackage

// File: rtl/zircon_adc_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush.
// Push while full is dropped unless a pop happens in the same cycle.
module zircon_adc_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [DEPTH_LOG2:0] DEPTH_C =
    (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [DATA_W-1:0]     mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == DEPTH_C);
  assign count   = cnt_q;
  assign dout    = mem_q[rptr_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // Pointer and occupancy update; flush wins over push/pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/zircon_avalon_adc_fifo.sv
// Avalon-MM front end for the TLC549 sample FIFO: registers, decimator, irq.
// Block averaging is built only when ZIRCON_ADC_FIFO_AVG_EN is defined.
module zircon_avalon_adc_fifo
  import zircon_adc_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AVG_LOG2   = 3
) (
  input  logic              csi_clk,
  input  logic              rsi_reset,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              ins_irq
);

  localparam int FW = CTRL_FIELD_W;

  logic          enable_q, enable_d;
  logic [FW-1:0] decim_q, decim_d;
  logic [FW-1:0] thresh_q, thresh_d;
  logic [FW-1:0] dcnt_q, dcnt_d;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic [31:0]   rdata_q, rdata_d;

  logic                ctrl_wr, stat_wr, flush;
  logic                accept, pop_req;
  logic [DATA_W-1:0]   dout;
  logic [DEPTH_LOG2:0] count;
  logic                full, empty;
  logic                unused_wdata;

  assign ctrl_wr = avs_write && (avs_address == ADDR_CTRL);
  assign stat_wr = avs_write && (avs_address == ADDR_STATUS);
  assign flush   = ctrl_wr && avs_writedata[CTRL_FLUSH_BIT];
  assign pop_req = avs_read && (avs_address == ADDR_DATA);
  assign accept  = sample_valid && enable_q && (dcnt_q == decim_q);
  assign unused_wdata = ^{avs_writedata[31:24], avs_writedata[7:2]};

  zircon_adc_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (csi_clk),
    .rst   (rsi_reset),
    .push  (accept),
    .pop   (pop_req),
    .flush (flush),
    .din   (sample_data),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef ZIRCON_ADC_FIFO_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] acnt_q, acnt_d;
  logic [DATA_W-1:0]   avg_q, avg_d;
  logic                avgv_q, avgv_d;

  assign acc_sum = acc_q + ACC_W'(sample_data);

  // Sum accepted samples; publish mean after each full block
  always_comb begin
    acc_d  = acc_q;
    acnt_d = acnt_q;
    avg_d  = avg_q;
    avgv_d = avgv_q;
    if (avs_read && (avs_address == ADDR_AVG)) avgv_d = 1'b0;
    if (flush || !enable_q) begin
      acc_d  = '0;
      acnt_d = '0;
    end else if (accept) begin
      if (&acnt_q) begin
        avg_d  = acc_sum[ACC_W-1:AVG_LOG2];
        avgv_d = 1'b1;
        acc_d  = '0;
        acnt_d = '0;
      end else begin
        acc_d  = acc_sum;
        acnt_d = acnt_q + 1'b1;
      end
    end
  end

  // Averager registers
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      acc_q  <= '0;
      acnt_q <= '0;
      avg_q  <= '0;
      avgv_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      acnt_q <= acnt_d;
      avg_q  <= avg_d;
      avgv_q <= avgv_d;
    end
  end
`else
  localparam int unused_avg_log2 = AVG_LOG2;
`endif

  // Control, decimator, overflow, irq and read mux
  always_comb begin
    enable_d = enable_q;
    decim_d  = decim_q;
    thresh_d = thresh_q;
    dcnt_d   = dcnt_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;
    irq_d    = enable_q && (thresh_q != '0) &&
               (32'(count) >= 32'(thresh_q));

    if (ctrl_wr || !enable_q)  dcnt_d = '0;
    else if (sample_valid)     dcnt_d = accept ? '0 : dcnt_q + 1'b1;

    if (ctrl_wr) begin
      enable_d = avs_writedata[CTRL_EN_BIT];
      decim_d  = avs_writedata[CTRL_DECIM_LSB +: FW];
      thresh_d = avs_writedata[CTRL_THRESH_LSB +: FW];
    end

    if (stat_wr && avs_writedata[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (accept && !flush && full && !(pop_req && !empty))
      ovf_d = 1'b1;

    if (avs_read) begin
      rdata_d = '0;
      unique case (avs_address)
        ADDR_DATA: begin
          if (!empty) begin
            rdata_d[DATA_VALID_BIT] = 1'b1;
            rdata_d[DATA_W-1:0]     = dout;
          end
        end
        ADDR_STATUS: begin
          rdata_d[DEPTH_LOG2:0]   = count;
          rdata_d[STAT_EMPTY_BIT] = empty;
          rdata_d[STAT_FULL_BIT]  = full;
          rdata_d[STAT_OVF_BIT]   = ovf_q;
        end
        ADDR_CTRL: begin
          rdata_d[CTRL_EN_BIT]            = enable_q;
          rdata_d[CTRL_DECIM_LSB +: FW]  = decim_q;
          rdata_d[CTRL_THRESH_LSB +: FW] = thresh_q;
        end
        ADDR_AVG: begin
`ifdef ZIRCON_ADC_FIFO_AVG_EN
          rdata_d[AVG_VALID_BIT] = avgv_q;
          rdata_d[DATA_W-1:0]    = avg_q;
`endif
        end
        default: rdata_d = '0;
      endcase
    end
  end

  // Register file state
  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      enable_q <= 1'b0;
      decim_q  <= '0;
      thresh_q <= '0;
      dcnt_q   <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      enable_q <= enable_d;
      decim_q  <= decim_d;
      thresh_q <= thresh_d;
      dcnt_q   <= dcnt_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign ins_irq      = irq_q;

endmodule
